// File: rtl/uma_and_seq_if.sv
// uma_and_seq_if: operand/randomness/result handshake bundle for the masked AND gadget
interface uma_and_seq_if #(parameter int SHARES = 3);
  logic              in_valid, in_ready, rand_valid, rand_ack, out_valid, out_ready;
  logic [SHARES-1:0] a_shares, b_shares, out_shares;
  logic [SHARES-2:0] rand_bits;
  modport master (
    output in_valid, a_shares, b_shares, rand_bits, rand_valid, out_ready,
    input  in_ready, rand_ack, out_valid, out_shares
  );
  modport slave (
    input  in_valid, a_shares, b_shares, rand_bits, rand_valid, out_ready,
    output in_ready, rand_ack, out_valid, out_shares
  );
endinterface

// File: rtl/uma_and_seq.sv
// uma_and_seq: handshaked SHARES-share masked AND, one cross-product rotation accumulated per cycle
module uma_and_seq #(
  parameter int SHARES = 3
) (
  input logic          clk,
  input logic          rst_n,
  uma_and_seq_if.slave bus
);
  localparam int KW = $clog2(SHARES + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                        r_state, w_next;
  logic [KW-1:0]                 r_k;
  logic [SHARES-1:0]             r_a, r_b, r_acc, w_term;
  logic [SHARES-1:0][SHARES-1:0] w_rot;
  logic                          w_in_ready, w_accept;
  // w_rot[d][i] = a_i & b_{(i+d) mod SHARES}; indices fold at elaboration
  for (genvar d = 0; d < SHARES; d++) begin : g_rot
    for (genvar i = 0; i < SHARES; i++) begin : g_bit
      assign w_rot[d][i] = r_a[i] & r_b[(i + d) % SHARES];
    end
  end
  always_comb begin
    w_term = '0;
    for (int d = 0; d < SHARES; d++)
      if (r_k == KW'(SHARES - d)) w_term = w_rot[d];
  end
  assign w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  // rst_n gating keeps rand_ack low while reset is held
  assign w_accept       = bus.in_valid & bus.rand_valid & w_in_ready & rst_n;
  assign bus.in_ready   = w_in_ready;
  assign bus.rand_ack   = w_accept;
  assign bus.out_valid  = (r_state == DONE);
  assign bus.out_shares = r_acc;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = ACCUM;
    else if (r_state == ACCUM && r_k == KW'(SHARES)) w_next = DONE;
    else if (r_state == DONE && bus.out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= bus.a_shares;
        r_b   <= bus.b_shares;
        r_acc <= {^bus.rand_bits, bus.rand_bits};
        r_k   <= KW'(1);
      end else if (r_state == ACCUM) begin
        r_acc <= r_acc ^ w_term;
        if (r_k != KW'(SHARES)) r_k <= r_k + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uma_and_seq.sv
// tb_uma_and_seq: vector table and handshake corner cases at SHARES=3, randomized sweep at SHARES=2,4,5
module tb_uma_and_seq;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int sweeps_done = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  uma_and_seq_if #(.SHARES(3)) m3 ();
  uma_and_seq #(.SHARES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(m3.slave));

  // each output share carries its refresh bit plus a_i & b (all cross terms for fixed i)
  function automatic logic [2:0] model3(input logic [2:0] a, input logic [2:0] b, input logic [1:0] r);
    logic [2:0] rv;
    rv = {^r, r};
    return rv ^ (a & {3{^b}});
  endfunction

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] r;
    logic [2:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic wait_result(output logic [2:0] res, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m3.out_valid && lat < 20);
    res = m3.out_shares;
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic [1:0] r,
                     output logic [2:0] res, output int lat);
    int t;
    @(negedge clk);
    m3.a_shares = a; m3.b_shares = b; m3.rand_bits = r;
    m3.in_valid = 1; m3.rand_valid = 1; m3.out_ready = 0;
    #1;
    t = 0;
    while (!m3.in_ready && t < 20) begin @(negedge clk); #1; t++; end
    check("op_in_ready", m3.in_ready, 1);
    check("op_rand_ack", m3.rand_ack, 1);
    @(posedge clk); #1;
    m3.in_valid = 0; m3.rand_valid = 0;
    m3.a_shares = ~a; m3.b_shares = ~b; m3.rand_bits = ~r;
    wait_result(res, lat);
  endtask

  task automatic retire3;
    @(negedge clk); m3.out_ready = 1;
    @(posedge clk); #1; m3.out_ready = 0;
  endtask

  initial begin
    logic [2:0] res, held, exp;
    int lat, acks;
    vt = '{'{3'b101, 3'b011, 2'b01, 3'b101},
           '{3'b111, 3'b010, 2'b10, 3'b001},
           '{3'b000, 3'b111, 2'b00, 3'b000},
           '{3'b110, 3'b100, 2'b11, 3'b101},
           '{3'b011, 3'b001, 2'b11, 3'b000},
           '{3'b100, 3'b110, 2'b01, 3'b101}};
    m3.in_valid = 0; m3.rand_valid = 0; m3.out_ready = 0;
    m3.a_shares = 0; m3.b_shares = 0; m3.rand_bits = 0;
    #2 rst_n = 0;
    #1;
    check("rst_out_valid", m3.out_valid, 0);
    check("rst_out_shares", m3.out_shares, 0);
    check("rst_in_ready", m3.in_ready, 1);
    check("rst_rand_ack", m3.rand_ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 6; n++) begin
      op3(vt[n].a, vt[n].b, vt[n].r, res, lat);
      check($sformatf("vec%0d_out", n), res, vt[n].exp);
      check($sformatf("vec%0d_lat", n), lat, 3);
      check($sformatf("vec%0d_xor", n), ^res, (^vt[n].a) & (^vt[n].b));
      retire3;
      check($sformatf("vec%0d_idle", n), m3.out_valid, 0);
    end
    // randomness stall: operands offered, no fresh randomness for 4 cycles
    @(negedge clk);
    m3.a_shares = 3'b110; m3.b_shares = 3'b011; m3.rand_bits = 2'b10;
    m3.in_valid = 1; m3.rand_valid = 0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_rand_ack", m3.rand_ack, 0);
      acks += int'(m3.rand_ack);
      @(posedge clk); #1;
      check("stall_still_idle", m3.in_ready, 1);
      @(negedge clk);
    end
    m3.rand_valid = 1;
    #1;
    check("stall_release_ack", m3.rand_ack, 1);
    acks += int'(m3.rand_ack);
    @(posedge clk); #1;
    m3.in_valid = 0; m3.rand_valid = 0; m3.a_shares = 0; m3.b_shares = 0;
    acks += int'(m3.rand_ack);
    check("stall_ack_pulses", acks, 1);
    check("stall_busy", m3.in_ready, 0);
    wait_result(res, lat);
    check("stall_lat", lat, 3);
    check("stall_out", res, model3(3'b110, 3'b011, 2'b10));
    // backpressure: new operands offered while the result is held
    held = m3.out_shares;
    @(negedge clk);
    m3.a_shares = 3'b011; m3.b_shares = 3'b101; m3.rand_bits = 2'b01;
    m3.in_valid = 1; m3.rand_valid = 1; m3.out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", m3.in_ready, 0);
      check("bp_rand_ack", m3.rand_ack, 0);
      check("bp_out_valid", m3.out_valid, 1);
      check("bp_out_stable", m3.out_shares, held);
      @(negedge clk);
    end
    m3.out_ready = 1;
    #1;
    check("b2b_in_ready", m3.in_ready, 1);
    check("b2b_rand_ack", m3.rand_ack, 1);
    @(posedge clk); #1;
    m3.out_ready = 0; m3.in_valid = 0; m3.rand_valid = 0; m3.a_shares = 3'b111;
    check("b2b_retired", m3.out_valid, 0);
    wait_result(res, lat);
    check("b2b_lat", lat, 3);
    exp = model3(3'b011, 3'b101, 2'b01);
    check("b2b_out", res, exp);
    retire3;
    // reset mid-ACCUM discards the operation
    @(negedge clk);
    m3.a_shares = 3'b111; m3.b_shares = 3'b111; m3.rand_bits = 2'b11;
    m3.in_valid = 1; m3.rand_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("midrst_out_valid", m3.out_valid, 0);
    check("midrst_out_shares", m3.out_shares, 0);
    check("midrst_in_ready", m3.in_ready, 1);
    check("midrst_rand_ack", m3.rand_ack, 0);
    @(negedge clk);
    m3.in_valid = 0; m3.rand_valid = 0;
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("midrst_no_result", m3.out_valid, 0);
    end
    for (int t = 0; t < 60000 && sweeps_done < 3; t++) @(posedge clk);
    check("sweeps_finished", sweeps_done, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int S = (g == 0) ? 2 : (g == 1) ? 4 : 5;
    logic srst_n = 1;
    uma_and_seq_if #(.SHARES(S)) sb ();
    uma_and_seq #(.SHARES(S)) sdut (.clk(clk), .rst_n(srst_n), .bus(sb.slave));

    function automatic logic [S-1:0] model(input logic [S-1:0] a, input logic [S-1:0] b,
                                          input logic [S-2:0] r);
      logic [S-1:0] rv;
      rv = {^r, r};
      return rv ^ (a & {S{^b}});
    endfunction

    initial begin
      logic [S-1:0] a, b, res;
      logic [S-2:0] r;
      int lat;
      sb.in_valid = 0; sb.rand_valid = 0; sb.out_ready = 0;
      sb.a_shares = 0; sb.b_shares = 0; sb.rand_bits = 0;
      #2 srst_n = 0;
      @(negedge clk);
      srst_n = 1;
      for (int n = 0; n < 1000; n++) begin
        a = S'($urandom); b = S'($urandom); r = (S-1)'($urandom);
        @(negedge clk);
        sb.a_shares = a; sb.b_shares = b; sb.rand_bits = r;
        sb.in_valid = 1; sb.rand_valid = 1;
        #1;
        check($sformatf("sweep%0d_ack", S), sb.rand_ack, 1);
        @(posedge clk); #1;
        sb.in_valid = 0; sb.rand_valid = 0;
        sb.a_shares = S'($urandom); sb.b_shares = S'($urandom); sb.rand_bits = (S-1)'($urandom);
        lat = 0;
        do begin
          @(posedge clk); #1;
          lat++;
        end while (!sb.out_valid && lat < 40);
        res = sb.out_shares;
        check($sformatf("sweep%0d_lat", S), lat, S);
        check($sformatf("sweep%0d_out", S), res, model(a, b, r));
        check($sformatf("sweep%0d_xor", S), ^res, (^a) & (^b));
        @(negedge clk); sb.out_ready = 1;
        @(posedge clk); #1; sb.out_ready = 0;
      end
      sweeps_done++;
    end
  end
endmodule
